// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings and default latencies for the hazard scoreboard.
package hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_LOAD = 2'd1,
        CLS_MUL  = 2'd2,
        CLS_DIV  = 2'd3
    } cls_e;

    localparam int DEF_NREG     = 32;
    localparam int DEF_CW       = 3;
    localparam int DEF_LOAD_LAT = 2;
    localparam int DEF_MUL_LAT  = 3;

endpackage

// File: rtl/hazard_scoreboard_counter.sv
// hs_counter: one per-register countdown entry with load, restore, divide-done and decrement controls.
module hs_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          restore,
    input  logic [CW-1:0] restore_val,
    input  logic          dec,
    input  logic          done,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] CMAX = '1;

    // All-ones marks a divide in flight; only div_done moves it, straight to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (restore) begin
            cnt <= (done && restore_val == CMAX) ? CW'(1) : restore_val;
        end else if (done && cnt == CMAX) begin
            cnt <= CW'(1);
        end else if (dec && cnt != '0 && cnt != CMAX) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard tracking per-register forwarding countdowns; produces stall/flush controls for FS/DS/ES/MS.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG     = DEF_NREG,
    parameter int CW       = DEF_CW,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int MUL_LAT  = DEF_MUL_LAT,
    parameter int RW       = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ds_valid,
    input  logic [RW-1:0]   ds_rs1,
    input  logic [RW-1:0]   ds_rs2,
    input  logic [RW-1:0]   ds_rd,
    input  logic            ds_wen,
    input  logic [1:0]      ds_cls,
    input  logic            ds_br,
    input  logic            div_busy,
    input  logic            div_done,
    input  logic            es_ex,
    input  logic            es_eret_flush,
    output logic            fs_stall,
    output logic            ds_stall,
    output logic            es_flush,
    output logic            es_stall,
    output logic            ds_flush,
    output logic            ms_flush,
    output logic [NREG-1:0] busy_vec
);

    localparam logic [CW-1:0] CMAX = '1;

    logic [CW-1:0] cnt [NREG];
    logic          flush, frz, raw_stall, issue, hz1, hz2, div_pend;
    logic [CW-1:0] thr, load_val, restore_val;
    logic          last_v, last_div;
    logic [RW-1:0] last_rd;
    logic [CW-1:0] last_prev;

    function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
        if (v == CMAX) return CMAX;
        if (v == '0)   return '0;
        return v - 1'b1;
    endfunction

    always_comb begin
        flush       = es_ex | es_eret_flush;
        frz         = div_busy & ~flush;
        // Branches resolve in DS, so they need the value one cycle earlier than ES consumers.
        thr         = ds_br ? CW'(1) : CW'(2);
        hz1         = (ds_rs1 != '0) && (cnt[ds_rs1] >= thr);
        hz2         = (ds_rs2 != '0) && (cnt[ds_rs2] >= thr);
        raw_stall   = ds_valid && (hz1 || hz2 || (ds_cls == CLS_DIV && ds_wen && div_pend));
        ds_stall    = frz | (raw_stall & ~flush);
        fs_stall    = ds_stall;
        es_stall    = frz;
        es_flush    = flush | raw_stall;
        ds_flush    = flush;
        ms_flush    = es_ex;
        issue       = ds_valid && !ds_stall && !flush && ds_wen && (ds_rd != '0);
        restore_val = sat_dec(last_prev);
        case (ds_cls)
            CLS_ALU:  load_val = CW'(1);
            CLS_LOAD: load_val = CW'(LOAD_LAT);
            CLS_MUL:  load_val = CW'(MUL_LAT);
            default:  load_val = CMAX;
        endcase
    end

    assign cnt[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        hs_counter #(.CW(CW)) u_cnt (
            .clk         (clk),
            .reset       (reset),
            .load        (issue && ds_rd == RW'(r)),
            .load_val    (load_val),
            .restore     (flush && last_v && last_rd == RW'(r)),
            .restore_val (restore_val),
            .dec         (~frz),
            .done        (div_done),
            .cnt         (cnt[r])
        );
    end

    for (genvar r = 0; r < NREG; r++) begin : g_busy
        assign busy_vec[r] = (cnt[r] != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_pend <= 1'b0;
            last_v   <= 1'b0;
        end else begin
            if (issue && ds_cls == CLS_DIV) begin
                div_pend <= 1'b1;
            end else if (div_done) begin
                div_pend <= 1'b0;
            end else if (flush && last_v && last_div && last_prev != CMAX) begin
                div_pend <= 1'b0;
            end
            if (!frz) begin
                last_v <= issue;
            end
        end
    end

    // Undo record for the most recent issue, consumed if ES flushes next cycle.
    always_ff @(posedge clk) begin
        if (issue) begin
            last_rd   <= ds_rd;
            last_prev <= cnt[ds_rd];
            last_div  <= (ds_cls == CLS_DIV);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_hazard_scoreboard;

    localparam int NREG = 32;
    localparam int RW   = 5;
    localparam int CMAX = 7;
    localparam int ALU = 0, LOAD = 1, MUL = 2, DIV = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            ds_valid, ds_wen, ds_br;
    logic [RW-1:0]   ds_rs1, ds_rs2, ds_rd;
    logic [1:0]      ds_cls;
    logic            div_busy, div_done, es_ex, es_eret_flush;
    logic            fs_stall, ds_stall, es_flush, es_stall, ds_flush, ms_flush;
    logic [NREG-1:0] busy_vec;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NREG(NREG), .CW(3), .LOAD_LAT(2), .MUL_LAT(3)) dut (
        .clk(clk), .reset(reset),
        .ds_valid(ds_valid), .ds_rs1(ds_rs1), .ds_rs2(ds_rs2), .ds_rd(ds_rd),
        .ds_wen(ds_wen), .ds_cls(ds_cls), .ds_br(ds_br),
        .div_busy(div_busy), .div_done(div_done), .es_ex(es_ex), .es_eret_flush(es_eret_flush),
        .fs_stall(fs_stall), .ds_stall(ds_stall), .es_flush(es_flush), .es_stall(es_stall),
        .ds_flush(ds_flush), .ms_flush(ms_flush), .busy_vec(busy_vec)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: remaining cycles until each register is forwardable.
    int  mc [NREG];
    int  nc [NREG];
    bit  mpend, mlv, mldiv, npend, nlv, nldiv;
    int  mlrd, mlprev, nlrd, nlprev;
    bit  e_ds, e_esf, e_ess, e_dsf, e_msf, m_issue;
    logic [NREG-1:0] e_busy;
    bit  obs_stall, obs_ess, obs_esf, obs_dsf, obs_msf;
    logic [NREG-1:0] obs_busy;

    function automatic int latency(input int cls);
        case (cls)
            ALU:     return 1;
            LOAD:    return 2;
            MUL:     return 3;
            default: return CMAX;
        endcase
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) mc[r] = 0;
        mpend = 0; mlv = 0; mldiv = 0; mlrd = 0; mlprev = 0;
    endtask

    task automatic model_eval();
        bit fl, fz, raw;
        int thr;
        fl  = es_ex || es_eret_flush;
        fz  = div_busy && !fl;
        thr = ds_br ? 1 : 2;
        raw = ds_valid && ((ds_rs1 != 0 && mc[ds_rs1] >= thr) ||
                           (ds_rs2 != 0 && mc[ds_rs2] >= thr) ||
                           (ds_cls == DIV && ds_wen && mpend));
        e_ess = fz;
        e_ds  = fz || (raw && !fl);
        e_esf = fl || raw;
        e_dsf = fl;
        e_msf = es_ex;
        for (int r = 0; r < NREG; r++) e_busy[r] = (mc[r] != 0);
        m_issue = ds_valid && !e_ds && !fl && ds_wen && ds_rd != 0;
        // Age every entry, then undo a killed issue, then apply the new issue.
        for (int r = 0; r < NREG; r++) begin
            nc[r] = mc[r];
            if (mc[r] == CMAX) begin
                if (div_done) nc[r] = 1;
            end else if (!fz && mc[r] > 0) begin
                nc[r] = mc[r] - 1;
            end
        end
        npend = div_done ? 0 : mpend;
        if (fl && mlv) begin
            if (mlprev == CMAX) nc[mlrd] = div_done ? 1 : CMAX;
            else                nc[mlrd] = (mlprev > 0) ? mlprev - 1 : 0;
            if (mldiv && mlprev != CMAX) npend = 0;
        end
        nlrd = mlrd; nlprev = mlprev; nldiv = mldiv;
        if (m_issue) begin
            nc[ds_rd] = latency(ds_cls);
            if (ds_cls == DIV) npend = 1;
            nlrd = ds_rd; nlprev = mc[ds_rd]; nldiv = (ds_cls == DIV);
        end
        nlv = fz ? mlv : m_issue;
    endtask

    task automatic cycle();
        model_eval();
        @(negedge clk);
        check("fs_stall", fs_stall, e_ds);
        check("ds_stall", ds_stall, e_ds);
        check("es_flush", es_flush, e_esf);
        check("es_stall", es_stall, e_ess);
        check("ds_flush", ds_flush, e_dsf);
        check("ms_flush", ms_flush, e_msf);
        check("busy_vec", busy_vec, e_busy);
        obs_stall = ds_stall; obs_ess = es_stall; obs_esf = es_flush;
        obs_dsf = ds_flush; obs_msf = ms_flush; obs_busy = busy_vec;
        @(posedge clk);
        mc = nc; mpend = npend; mlv = nlv; mlrd = nlrd; mlprev = nlprev; mldiv = nldiv;
        #1;
    endtask

    task automatic drive(input bit v, input int rs1, input int rs2, input int rd,
                         input bit wen, input int cls, input bit br);
        ds_valid = v; ds_rs1 = rs1[RW-1:0]; ds_rs2 = rs2[RW-1:0]; ds_rd = rd[RW-1:0];
        ds_wen = wen; ds_cls = cls[1:0]; ds_br = br;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, ALU, 0);
        repeat (n) cycle();
    endtask

    // Holds the current DS instruction until it stops stalling; counts stall cycles.
    task automatic run_until_issue(input string tag, input int exp_stalls);
        int n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (!obs_stall) break;
            n++;
        end
        check(tag, n, exp_stalls);
        drive(0, 0, 0, 0, 0, ALU, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int es_cnt, div_left;
        bit done_now, allow;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, ALU, 0);
        div_busy = 0; div_done = 0; es_ex = 0; es_eret_flush = 0;
        model_reset();
        #1;
        check("rst_busy_vec", busy_vec, 0);
        check("rst_ds_stall", ds_stall, 0);
        check("rst_es_flush", es_flush, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);

        // Load-use: one bubble.
        drive(1, 0, 0, 5, 1, LOAD, 0); cycle();
        drive(1, 5, 0, 6, 1, ALU, 0);  run_until_issue("load_use_stalls", 1);
        idle(4);
        drive(1, 0, 0, 5, 1, LOAD, 0); cycle();
        drive(1, 5, 0, 0, 0, ALU, 1);  run_until_issue("load_branch_stalls", 2);
        idle(4);
        drive(1, 0, 0, 5, 1, ALU, 0);  cycle();
        drive(1, 0, 5, 0, 0, ALU, 1);  run_until_issue("alu_branch_stalls", 1);
        idle(4);
        drive(1, 0, 0, 5, 1, ALU, 0);  cycle();
        drive(1, 5, 0, 6, 1, ALU, 0);  run_until_issue("alu_use_stalls", 0);
        idle(4);

        // Divide with the divider busy for 10 cycles.
        drive(1, 0, 0, 7, 1, DIV, 0); cycle();
        drive(1, 7, 0, 8, 1, ALU, 0);
        div_busy = 1; es_cnt = 0;
        repeat (10) begin cycle(); es_cnt += obs_ess; end
        check("div_es_stall_cycles", es_cnt, 10);
        div_busy = 0; div_done = 1; cycle();
        check("div_done_cycle_stall", obs_stall, 1);
        div_done = 0;
        run_until_issue("div_use_after_done", 0);
        idle(4);

        // Multiply killed by an exception in ES.
        drive(1, 0, 0, 3, 1, ALU, 0); cycle();
        drive(1, 0, 0, 3, 1, MUL, 0); cycle();
        es_ex = 1; drive(1, 3, 0, 9, 1, ALU, 0); cycle();
        check("ex_ds_flush", obs_dsf, 1);
        check("ex_es_flush", obs_esf, 1);
        check("ex_ms_flush", obs_msf, 1);
        check("ex_no_stall", obs_stall, 0);
        es_ex = 0; drive(1, 3, 0, 0, 0, ALU, 1); cycle();
        check("r3_free_after_restore", obs_stall, 0);
        check("r3_busy_after_restore", obs_busy[3], 0);
        idle(8);

        // Asynchronous reset with a load outstanding and a divide pending.
        drive(1, 0, 0, 7, 1, DIV, 0);  cycle();
        drive(1, 0, 0, 4, 1, LOAD, 0); cycle();
        drive(1, 0, 0, 10, 1, DIV, 0);
        #2;
        check("pre_rst_div_stall", ds_stall, 1);
        check("pre_rst_busy4", busy_vec[4], 1);
        reset = 1'b1;
        #1;
        check("async_rst_busy_vec", busy_vec, 0);
        check("async_rst_ds_stall", ds_stall, 0);
        check("async_rst_fs_stall", fs_stall, 0);
        check("async_rst_es_stall", es_stall, 0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        cycle();
        check("div_after_rst_issues", obs_stall, 0);
        idle(2);
        drive(0, 0, 0, 0, 0, ALU, 0);
        idle(1);

        // Randomized traffic with a well-behaved divider.
        div_left = 0; done_now = 0;
        repeat (600) begin
            div_busy = (div_left > 0);
            div_done = done_now;
            allow = !mpend && div_left == 0 && !done_now;
            es_ex = allow && ($urandom_range(0, 11) == 0);
            es_eret_flush = allow && ($urandom_range(0, 15) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 9) < 7, $urandom_range(0, 3),
                  $urandom_range(0, 4) == 0);
            cycle();
            done_now = 0;
            if (div_left > 0) begin
                div_left--;
                if (div_left == 0) done_now = 1;
            end
            if (m_issue && ds_cls == DIV) div_left = $urandom_range(1, 5);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, meaning number of architectural registers; register 0 is never tracked.
REQ-002 SHALL have parameter CW, default 3, meaning countdown counter width; all-ones (CMAX) means "div pending".
REQ-003 SHALL have parameter LOAD_LAT, default 2, meaning countdown loaded for a load destination; legal range 1..CMAX-1.
REQ-004 SHALL have parameter MUL_LAT, default 3, meaning countdown loaded for a multiply destination; legal range 1..CMAX-1.
REQ-005 SHALL have parameter RW = $clog2(NREG) as a derived register-index width.
REQ-006 Ports are one clock and one asynchronous active-high reset; all other ports follow in order.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- ds_valid  in  1  DS holds a valid instruction.
- ds_rs1, ds_rs2  in  RW each  DS source registers; value 0 means unused.
- ds_rd  in  RW  DS destination register.
- ds_wen  in  1  DS instruction writes ds_rd.
- ds_cls  in  2  destination class: 0 ALU, 1 LOAD, 2 MUL, 3 DIV.
- ds_br  in  1  DS instruction is a branch resolved in DS.
- div_busy  in  1  divider busy; ES frozen.
- div_done  in  1  single-cycle pulse; divider result is forwardable next cycle.
- es_ex  in  1  exception in ES.
- es_eret_flush  in  1  ERET in ES.
- fs_stall, ds_stall  out  1 each  hold FS/DS.
- es_flush  out  1  insert bubble into ES.
- es_stall  out  1  hold ES.
- ds_flush, ms_flush  out  1 each  kill DS/MS.
- busy_vec  out  NREG  bit r set when cnt[r] != 0, debug only.

Function
REQ-007 SHALL keep cnt[r] (CW bits) per register: cycles until r is forwardable to ES; entries 0 and 1 carry no hazard for non-branch consumers.
REQ-008 Definitions: flush = es_ex | es_eret_flush; frz = div_busy & ~flush; src hazard for source s = (s != 0) & (cnt[s] >= (ds_br ? 1 : 2)).
REQ-009 SHALL assert raw_stall = ds_valid & (hazard(rs1) | hazard(rs2) | (ds_cls==DIV & ds_wen & div_pend)).
REQ-010 SHALL assign es_flush = flush | raw_stall, ds_flush = flush, ms_flush = es_ex, es_stall = frz, and fs_stall = ds_stall = frz | (raw_stall & ~flush); all outputs are combinational.
REQ-011 issue = ds_valid & ~ds_stall & ~flush & ds_wen & (ds_rd != 0); on issue, cnt[ds_rd] loads 1 for ALU, LOAD_LAT for LOAD, MUL_LAT for MUL, or CMAX for DIV, with div_pend set to 1 for DIV.
REQ-012 Each cycle with ~frz, every cnt != 0 and != CMAX decrements by 1; on issue, the issue load takes priority over the decrement for that register.
REQ-013 When frz is 1, all counters hold and no issue occurs.
REQ-014 When div_done is 1, the CMAX entry SHALL become 1 and div_pend SHALL clear; div_done takes priority over decrement; if div_done coincides with a DS DIV, the DIV stalls that cycle.
REQ-015 SHALL record each issue in last_v/last_rd/last_prev, where last_prev is the pre-issue cnt value, and SHALL clear last_v on any non-issue, non-frozen cycle.
REQ-016 On flush with last_v=1, SHALL restore cnt[last_rd] to max(last_prev-1, 0) (CMAX is kept as CMAX) and clear last_v; if last_prev != CMAX and the killed instruction was DIV, div_pend SHALL clear.
REQ-017 Flush and raw_stall in the same cycle: flush wins; no issue and no stall.

Reset
REQ-018 On reset, all cnt, div_pend, and last_v SHALL be 0 immediately (asynchronous); outputs then reflect only combinational inputs; reset mid-divide abandons div_pend.

Structure
REQ-019 Shared package SHALL hold the class encoding constants (CLS_ALU/LOAD/MUL/DIV) and the default latency constants.
REQ-020 One sub-module, hs_counter (a single countdown entry with load/hold/restore controls), SHALL be instantiated NREG-1 times.

Verification
REQ-021 Load r5, then add using r5 in the next cycle -> ds_stall high for exactly 1 cycle, es_flush high for that cycle.
REQ-022 Load r5, then beq using r5 -> 2 stall cycles; ALU writes r5, then beq r5 -> 1 stall cycle; ALU writes r5, then add r5 -> 0 stall cycles.
REQ-023 div r7 with div_busy held 10 cycles, then add using r7 -> stalls until div_done, issues 1 cycle after div_done; es_stall high for all 10 cycles.
REQ-024 mul r3 issues, then es_ex next cycle -> cnt[3] restored to its prior value minus 1, ds_flush=es_flush=ms_flush=1, and no stall on r3 afterwards.
REQ-025 Assert reset with cnt[4]=2 and div_pend=1 -> busy_vec=0 and all stalls low in the same cycle.
